// File: rtl/bf_radix2_pipe.sv
// bf_radix2_pipe: three-stage pipelined radix-2 butterfly, Y0=(A+B)>>s, Y1=((A-B)*W)>>(FRAC_W+s)
// Ports: clk, rst_n (async low); in_valid/in_ready + a/b/w operands + scale in;
// out_valid/out_ready + y0/y1 out; ovf sticky saturation flag with ovf_clr.
module bf_radix2_pipe #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] a_re,
  input  logic signed [DATA_W-1:0] a_im,
  input  logic signed [DATA_W-1:0] b_re,
  input  logic signed [DATA_W-1:0] b_im,
  input  logic signed [DATA_W-1:0] w_re,
  input  logic signed [DATA_W-1:0] w_im,
  input  logic                     scale,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] y0_re,
  output logic signed [DATA_W-1:0] y0_im,
  output logic signed [DATA_W-1:0] y1_re,
  output logic signed [DATA_W-1:0] y1_im,
  output logic                     ovf,
  input  logic                     ovf_clr
);
  localparam int D1 = DATA_W + 1;
  localparam int P = 2 * DATA_W + 2;
  localparam logic signed [P-1:0] ONE = P'(1);
  localparam logic signed [P-1:0] MAXV = (ONE <<< (DATA_W - 1)) - ONE;
  localparam logic signed [P-1:0] MINV = -(ONE <<< (DATA_W - 1));
  localparam logic signed [P-1:0] H0 = ONE <<< (FRAC_W - 1);
  localparam logic signed [P-1:0] H1 = ONE <<< FRAC_W;
  function automatic logic signed [DATA_W-1:0] sat(input logic signed [P-1:0] v);
    return v > MAXV ? MAXV[DATA_W-1:0] : (v < MINV ? MINV[DATA_W-1:0] : v[DATA_W-1:0]);
  endfunction
  function automatic logic ov(input logic signed [P-1:0] v);
    return v > MAXV || v < MINV;
  endfunction
  logic en, v1, v2, v3, s1, s2, any_ov;
  logic signed [D1-1:0] sr1, si1, dr1, di1, sr2, si2;
  logic signed [DATA_W-1:0] wr1, wi1;
  logic signed [P-1:0] pr2, pi2, r0r, r0i, r1r, r1i;
  // Whole pipe advances together; it only stalls when a held output is refused.
  assign en = out_ready | ~v3;
  assign in_ready = en;
  assign out_valid = v3;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1 <= '0;
      s1 <= '0;
      sr1 <= '0;
      si1 <= '0;
      dr1 <= '0;
      di1 <= '0;
      wr1 <= '0;
      wi1 <= '0;
    end else if (en) begin
      v1 <= in_valid;
      s1 <= scale;
      sr1 <= D1'(a_re) + D1'(b_re);
      si1 <= D1'(a_im) + D1'(b_im);
      dr1 <= D1'(a_re) - D1'(b_re);
      di1 <= D1'(a_im) - D1'(b_im);
      wr1 <= w_re;
      wi1 <= w_im;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v2 <= '0;
      s2 <= '0;
      sr2 <= '0;
      si2 <= '0;
      pr2 <= '0;
      pi2 <= '0;
    end else if (en) begin
      v2 <= v1;
      s2 <= s1;
      sr2 <= sr1;
      si2 <= si1;
      pr2 <= P'(dr1) * P'(wr1) - P'(di1) * P'(wi1);
      pi2 <= P'(dr1) * P'(wi1) + P'(di1) * P'(wr1);
    end
  // Round-half-up: add half an LSB of the target scale, then arithmetic shift.
  always_comb begin
    r0r = s2 ? (P'(sr2) + ONE) >>> 1 : P'(sr2);
    r0i = s2 ? (P'(si2) + ONE) >>> 1 : P'(si2);
    r1r = (pr2 + (s2 ? H1 : H0)) >>> (s2 ? FRAC_W + 1 : FRAC_W);
    r1i = (pi2 + (s2 ? H1 : H0)) >>> (s2 ? FRAC_W + 1 : FRAC_W);
  end
  assign any_ov = ov(r0r) | ov(r0i) | ov(r1r) | ov(r1i);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v3 <= '0;
      y0_re <= '0;
      y0_im <= '0;
      y1_re <= '0;
      y1_im <= '0;
    end else if (en) begin
      v3 <= v2;
      y0_re <= sat(r0r);
      y0_im <= sat(r0i);
      y1_re <= sat(r1r);
      y1_im <= sat(r1i);
    end
  // Set has priority over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf <= '0;
    else if (en && v2 && any_ov) ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
endmodule

// File: doc/bf_radix2_pipe.md
BF_RADIX2_PIPE -- requirements
Module: bf_radix2_pipe

Interface
REQ-001 Parameter DATA_W, default 16: width of every real/imag data and twiddle port, two's complement.
REQ-002 Parameter FRAC_W, default 8: fractional bits of the twiddle fixed-point format; legal range 1..DATA_W-2.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 in_valid  in  1  input beat valid.
REQ-006 in_ready  out  1  block can accept an input beat this cycle.
REQ-007 a_re, a_im, b_re, b_im, w_re, w_im  in  DATA_W each  operands A, B and twiddle W, signed.
REQ-008 scale  in  1  sampled with the beat; 1 = divide both outputs by 2 (per-stage FFT scaling).
REQ-009 out_valid  out  1  output beat valid.
REQ-010 out_ready  in  1  downstream accepts the output beat.
REQ-011 y0_re, y0_im, y1_re, y1_im  out  DATA_W each  results, signed.
REQ-012 ovf  out  1  sticky saturation flag.
REQ-013 ovf_clr  in  1  synchronous clear of ovf.

Function
REQ-014 Results: Y0 = (A+B)/2^scale; Y1 = ((A-B)*W)/2^(FRAC_W+scale), with complex multiply re = Xr*Wr - Xi*Wi, im = Xr*Wi + Xi*Wr, where X = A-B.
REQ-015 A+B and A-B are computed at DATA_W+1 bits; products and their sums at 2*DATA_W+2 bits; no intermediate wrap is permitted.
REQ-016 Every right shift uses round-half-up: add 2^(k-1), then arithmetic shift right by k; a shift of k=0 leaves the value unchanged.
REQ-017 After rounding, each result saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-018 Pipeline has three registered stages: S1 add/sub, S2 multiply, S3 round/saturate; each stage carries its own valid bit and scale bit.
REQ-019 Latency is exactly 3 cycles from an accepted input (in_valid and in_ready high) to out_valid, when there is no backpressure.
REQ-020 Throughput is one beat per cycle while out_ready stays high.
REQ-021 Global advance enable en = out_ready OR NOT out_valid; all stages load only when en is high; in_ready = en.
REQ-022 Bubbles are not compressed; an empty stage propagates valid=0.
REQ-023 While out_valid is high and out_ready is low, all y* outputs and out_valid hold stable.
REQ-024 Input data is ignored when in_valid is low or in_ready is low.
REQ-025 Beats leave in acceptance order; no beat is lost or duplicated.
REQ-026 ovf sets in the cycle S3 loads a valid beat in which any of the four results saturated.
REQ-027 ovf_clr clears ovf on the next edge; if a set and a clear occur in the same cycle, set wins.

Reset
REQ-028 When rst_n is low: all stage valids = 0, out_valid = 0, ovf = 0, y* = 0; in_ready = 1 combinationally once rst_n is high.
REQ-029 Asserting rst_n mid-operation discards all in-flight beats; the first beat accepted after release appears 3 cycles later.

Verification (DATA_W=16, FRAC_W=8; values are integer codes)
REQ-030 A=(256,0), B=(128,0), W=(256,0), scale=0 -> 3 cycles later y0=(384,0), y1=(128,0), ovf=0.
REQ-031 A=(0,256), B=(0,0), W=(0,256), scale=0 -> y1=(-256,0) and y0=(0,256); this checks that y1_im is driven by the imaginary sum and not by the real part.
REQ-032 Saturation and ovf:
- A=(32767,-32768), B=(32767,-32768), scale=0 -> y0=(32767,-32768), ovf=1.
- ovf_clr pulse -> ovf=0.
- Same beat with scale=1 -> y0=(32767,-32768), ovf stays 0.
REQ-033 Rounding: A=(3,-3), B=(0,0), W=(256,0), scale=1 -> y0=(2,-1), y1=(2,-1).
REQ-034 Backpressure:
- Stimulus: stream of 6 distinct beats; out_ready low for cycles 4..9, then high.
- Response: in_ready falls when the pipeline is full; outputs hold stable while stalled; all 6 results arrive in order, none lost or duplicated.
REQ-035 Reset mid-stream: assert rst_n low with 2 beats in flight -> out_valid=0 immediately; after release, no stale beats emerge.
